// File: rtl/dbus_access_ctrl.sv
// dbus_access_ctrl
//   Data-bus sequencer between the single-cycle core and the data RAM / MMIO
//   bus. Each lw/sw becomes a timed access; cpu_stall holds the core until the
//   access retires in DONE. The UART program loader shares the RAM port and
//   wins arbitration in IDLE.
//
//   Ports
//     i_clk, i_rst_n           clock (rising edge), async active-low reset
//     i_cpu_mem_read/write     lw / sw to RAM
//     i_cpu_io_read/write      lw / sw to MMIO
//     i_cpu_addr, i_cpu_wdata  byte address and store data from execute
//     o_cpu_stall              combinational hold for PC and regfile write
//     o_cpu_rdata, o_cpu_rvalid load data and its 1-cycle completion pulse
//     o_bus_err                1-cycle error pulse (multi-request or IO timeout)
//     i_ldr_wr, i_ldr_addr, i_ldr_wdata, o_ldr_ack   loader write port
//     o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, i_ram_rdata   RAM port
//     o_io_req, o_io_we, o_io_addr, o_io_wdata, i_io_rdata, i_io_ack  MMIO port
//     o_dbg_state              current FSM state
//
//   Handshakes: i_ldr_wr is held by the loader until o_ldr_ack pulses for one
//   cycle, which is the cycle the RAM write happens. o_io_req is held with
//   stable o_io_we/o_io_addr/o_io_wdata until i_io_ack is sampled high (the
//   transfer completes on that edge, i_io_rdata valid with it) or until
//   IO_TIMEOUT cycles pass; i_io_ack is ignored whenever o_io_req is low.
module dbus_access_ctrl #(
    parameter int RAM_AW     = 14,
    parameter int RAM_LAT    = 2,
    parameter int IO_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_mem_read,
    input  logic              i_cpu_mem_write,
    input  logic              i_cpu_io_read,
    input  logic              i_cpu_io_write,
    input  logic [31:0]       i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    output logic              o_cpu_stall,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_rvalid,
    output logic              o_bus_err,
    input  logic              i_ldr_wr,
    input  logic [RAM_AW-1:0] i_ldr_addr,
    input  logic [31:0]       i_ldr_wdata,
    output logic              o_ldr_ack,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata,
    output logic              o_io_req,
    output logic              o_io_we,
    output logic [9:0]        o_io_addr,
    output logic [31:0]       o_io_wdata,
    input  logic [31:0]       i_io_rdata,
    input  logic              i_io_ack,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LDR    = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_IO     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(RAM_LAT - 1);
    localparam logic [7:0] TO_M1  = 8'(IO_TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_cpu_rvalid;
    logic              r_bus_err;
    logic              r_ldr_ack;
    logic [31:0]       r_cpu_rdata;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic              r_io_req;
    logic              r_io_we;
    logic [9:0]        r_io_addr;
    logic [31:0]       r_io_wdata;

    logic [2:0]        w_req_cnt;
    logic              w_any_req;
    logic              w_multi_req;
    logic              w_unused_addr;

    assign w_req_cnt   = {2'b00, i_cpu_mem_read} + {2'b00, i_cpu_mem_write}
                       + {2'b00, i_cpu_io_read}  + {2'b00, i_cpu_io_write};
    assign w_any_req   = (w_req_cnt != 3'd0);
    assign w_multi_req = (w_req_cnt > 3'd1);

    // Address bits above the RAM window are not decoded here.
    assign w_unused_addr = &{1'b0, i_cpu_addr[31:RAM_AW+2]};

    // The core must freeze in the same cycle it presents a request, so the
    // IDLE term is combinational; DONE releases it so the instruction retires.
    assign o_cpu_stall = ((r_state == S_IDLE) && w_any_req)
                       || ((r_state != S_IDLE) && (r_state != S_DONE));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_cpu_rvalid <= 1'b0;
            r_bus_err    <= 1'b0;
            r_ldr_ack    <= 1'b0;
            r_cpu_rdata  <= 32'h0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= 32'h0;
            r_io_req     <= 1'b0;
            r_io_we      <= 1'b0;
            r_io_addr    <= 10'h0;
            r_io_wdata   <= 32'h0;
        end else begin
            // Pulse outputs are high for exactly one cycle after being set.
            r_cpu_rvalid <= 1'b0;
            r_bus_err    <= 1'b0;
            r_ldr_ack    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_ldr_wr) begin
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= i_ldr_addr;
                        r_ram_wdata <= i_ldr_wdata;
                        r_ldr_ack   <= 1'b1;
                        r_state     <= S_LDR;
                    end else if (w_multi_req) begin
                        r_bus_err <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (i_cpu_mem_read) begin
                        r_ram_en   <= 1'b1;
                        r_ram_we   <= 1'b0;
                        r_ram_addr <= i_cpu_addr[RAM_AW+1:2];
                        r_cnt      <= LAT_M1;
                        r_state    <= S_MEM_RD;
                    end else if (i_cpu_mem_write) begin
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= i_cpu_addr[RAM_AW+1:2];
                        r_ram_wdata <= i_cpu_wdata;
                        r_state     <= S_MEM_WR;
                    end else if (i_cpu_io_read || i_cpu_io_write) begin
                        // The io_* registers are the latched address/data
                        // and stay stable for the whole handshake.
                        r_io_req   <= 1'b1;
                        r_io_we    <= i_cpu_io_write;
                        r_io_addr  <= i_cpu_addr[9:0];
                        r_io_wdata <= i_cpu_wdata;
                        r_cnt      <= TO_M1;
                        r_state    <= S_IO;
                    end
                end
                S_LDR: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_MEM_WR: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_MEM_RD: begin
                    if (r_cnt == 8'd0) begin
                        r_cpu_rdata  <= i_ram_rdata;
                        r_cpu_rvalid <= 1'b1;
                        r_ram_en     <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_IO: begin
                    // Ack is checked first so an ack on the last allowed
                    // cycle still counts as success.
                    if (i_io_ack) begin
                        if (!r_io_we) begin
                            r_cpu_rdata <= i_io_rdata;
                        end
                        r_cpu_rvalid <= !r_io_we;
                        r_io_req     <= 1'b0;
                        r_state      <= S_DONE;
                    end else if (r_cnt == 8'd0) begin
                        r_cpu_rdata  <= 32'h0;
                        r_cpu_rvalid <= !r_io_we;
                        r_bus_err    <= 1'b1;
                        r_io_req     <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_bus_err    = r_bus_err;
    assign o_ldr_ack    = r_ldr_ack;
    assign o_ram_en     = r_ram_en;
    assign o_ram_we     = r_ram_we;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_wdata  = r_ram_wdata;
    assign o_io_req     = r_io_req;
    assign o_io_we      = r_io_we;
    assign o_io_addr    = r_io_addr;
    assign o_io_wdata   = r_io_wdata;
    assign o_dbg_state  = r_state;

endmodule
